// File: rtl/mul_uart_frontend_pkg.sv
// Shared types and constants for the UART front end of the 8x8 multiplier.
package mul_uart_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    CAPTURE = 3'd2,
    SEND_1  = 3'd3,
    SEND_2  = 3'd4
  } state_e;

  localparam bit BYTE_ORDER_HIGH_FIRST = 1'b1;
  localparam bit BYTE_ORDER_LOW_FIRST  = 1'b0;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int timer_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mul_uart_frontend_byte_timeout_ctr.sv
// Inter-byte timeout counter: counts while enabled, pulses expire on its last count.
module byte_timeout_ctr
  import mul_uart_pkg::*;
#(
  parameter int LIMIT = 1000,
  parameter int CNT_W = timer_w(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/mul_uart_frontend.sv
// Frames two received bytes into multiplier operands and streams the 16-bit product back out.
module mul_uart_frontend
  import mul_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter bit HIGH_FIRST     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] mul_a,
  output logic [7:0] mul_b,
  input  logic [7:0] mul_prod_low,
  input  logic [7:0] mul_prod_high,
  output logic       busy,
  output logic       timeout,
  output logic       rx_drop
);

  state_e      state_q, state_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        timeout_q, timeout_d;
  logic        rx_drop_q, rx_drop_d;
  logic        tmr_expire;

  function automatic logic [7:0] pick_byte(input logic [15:0] prod, input bit first);
    logic take_high;
    take_high = first ? (HIGH_FIRST == BYTE_ORDER_HIGH_FIRST)
                      : (HIGH_FIRST == BYTE_ORDER_LOW_FIRST);
    return take_high ? prod[15:8] : prod[7:0];
  endfunction

  byte_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != WAIT_B),
    .enable (state_q == WAIT_B),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    prod_d     = prod_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    timeout_d  = 1'b0;
    rx_drop_d  = 1'b0;

    unique case (state_q)
      WAIT_A: begin
        if (rx_valid && !rx_err) begin
          mul_a_d = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        // A received byte takes priority over a simultaneous expiry.
        if (rx_valid) begin
          if (!rx_err) begin
            mul_b_d = rx_data;
            state_d = CAPTURE;
          end else begin
            state_d = WAIT_A;
          end
        end else if (tmr_expire) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end
      end
      CAPTURE: begin
        // mul_b has been stable for a full cycle, so the core output has settled.
        prod_d     = {mul_prod_high, mul_prod_low};
        tx_data_d  = pick_byte({mul_prod_high, mul_prod_low}, 1'b1);
        tx_valid_d = 1'b1;
        state_d    = SEND_1;
      end
      SEND_1: begin
        if (tx_ready) begin
          tx_data_d = pick_byte(prod_q, 1'b0);
          state_d   = SEND_2;
        end
      end
      SEND_2: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase

    if (rx_valid && (state_q inside {CAPTURE, SEND_1, SEND_2})) begin
      rx_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_A;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      prod_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      prod_q     <= prod_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      timeout_q  <= timeout_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign timeout  = timeout_q;
  assign rx_drop  = rx_drop_q;
  assign busy     = (state_q != WAIT_A);

endmodule

// File: tb/tb_mul_uart_frontend.sv
// Directed bench for mul_uart_frontend with a behavioural 8x8 multiplier standing in for the core.
module tb_mul_uart_frontend;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_err;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] mul_a;
  logic [7:0] mul_b;
  logic [7:0] mul_prod_low;
  logic [7:0] mul_prod_high;
  logic       busy;
  logic       timeout;
  logic       rx_drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {mul_prod_high, mul_prod_low} = 16'(mul_a * mul_b);

  mul_uart_frontend #(
    .TIMEOUT_CYCLES (TO),
    .HIGH_FIRST     (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_err        (rx_err),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_prod_low  (mul_prod_low),
    .mul_prod_high (mul_prod_high),
    .busy          (busy),
    .timeout       (timeout),
    .rx_drop       (rx_drop)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic e);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_err   = e;
    tick();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  // Full frame with tx_ready already high: checks latency and both bytes.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] hi, input logic [7:0] lo);
    rx_byte(a, 1'b0);
    rx_byte(b, 1'b0);
    chk("cap_mul_a", 16'(mul_a), 16'(a));
    chk("cap_mul_b", 16'(mul_b), 16'(b));
    chk("cap_tx_valid", 16'(tx_valid), 16'd0);
    chk("cap_busy", 16'(busy), 16'd1);
    tick();
    chk("s1_tx_valid", 16'(tx_valid), 16'd1);
    chk("s1_tx_data", 16'(tx_data), 16'(hi));
    tick();
    chk("s2_tx_valid", 16'(tx_valid), 16'd1);
    chk("s2_tx_data", 16'(tx_data), 16'(lo));
    tick();
    chk("done_tx_valid", 16'(tx_valid), 16'd0);
    chk("done_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_err   = 1'b0;
    tx_ready = 1'b1;
    #3;
    chk("rst_tx_valid", 16'(tx_valid), 16'd0);
    chk("rst_tx_data", 16'(tx_data), 16'd0);
    chk("rst_mul_a", 16'(mul_a), 16'd0);
    chk("rst_mul_b", 16'(mul_b), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_timeout", 16'(timeout), 16'd0);
    chk("rst_rx_drop", 16'(rx_drop), 16'd0);
    #9 rst_n = 1'b1;
    tick();

    // 1: 0xFF * 0xFF = 0xFE01, high byte first
    do_frame(8'hFF, 8'hFF, 8'hFE, 8'h01);

    // 2: back-pressure holds the first byte stable
    tx_ready = 1'b0;
    rx_byte(8'h0C, 1'b0);
    rx_byte(8'h0D, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_valid", 16'(tx_valid), 16'd1);
      chk("bp_tx_data", 16'(tx_data), 16'h00);
      if (i == 9) tx_ready = 1'b1;
      tick();
    end
    chk("bp_second_valid", 16'(tx_valid), 16'd1);
    chk("bp_second_data", 16'(tx_data), 16'h9C);
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_extra", 16'(tx_valid), 16'd0);
      tick();
    end
    tx_ready = 1'b1;

    // 3: timeout after byte A, then a fresh frame
    rx_byte(8'h05, 1'b0);
    pulses = 0;
    for (int i = 0; i < TO; i++) begin
      if (timeout) pulses++;
      chk("to_wait_busy", 16'(busy), 16'd1);
      tick();
    end
    chk("to_early_pulses", 16'(pulses), 16'd0);
    chk("to_pulse", 16'(timeout), 16'd1);
    chk("to_busy", 16'(busy), 16'd0);
    chk("to_mul_a_kept", 16'(mul_a), 16'h05);
    tick();
    chk("to_pulse_end", 16'(timeout), 16'd0);
    do_frame(8'h03, 8'h04, 8'h00, 8'h0C);

    // 4: rx_err handling in WAIT_A and WAIT_B
    rx_byte(8'h99, 1'b1);
    chk("err_a_busy", 16'(busy), 16'd0);
    rx_byte(8'h07, 1'b0);
    chk("err_b_pre_busy", 16'(busy), 16'd1);
    rx_byte(8'h08, 1'b1);
    chk("err_b_busy", 16'(busy), 16'd0);
    chk("err_b_timeout", 16'(timeout), 16'd0);
    tick();
    chk("err_b_timeout2", 16'(timeout), 16'd0);
    do_frame(8'h02, 8'h80, 8'h01, 8'h00);

    // 5: byte arriving during SEND_1 is dropped
    tx_ready = 1'b0;
    rx_byte(8'h11, 1'b0);
    rx_byte(8'h22, 1'b0);
    tick();
    chk("drop_s1_data", 16'(tx_data), 16'h02);
    rx_byte(8'h55, 1'b0);
    chk("drop_pulse", 16'(rx_drop), 16'd1);
    chk("drop_tx_data", 16'(tx_data), 16'h02);
    chk("drop_tx_valid", 16'(tx_valid), 16'd1);
    chk("drop_mul_b", 16'(mul_b), 16'h22);
    tick();
    chk("drop_pulse_end", 16'(rx_drop), 16'd0);
    tx_ready = 1'b1;
    tick();
    chk("drop_second_data", 16'(tx_data), 16'h42);
    chk("drop_second_valid", 16'(tx_valid), 16'd1);
    tick();
    chk("drop_done", 16'(tx_valid), 16'd0);
    do_frame(8'h03, 8'h05, 8'h00, 8'h0F);

    // 6: asynchronous reset during SEND_2
    tx_ready = 1'b0;
    rx_byte(8'h0F, 1'b0);
    rx_byte(8'h11, 1'b0);
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("rst2_pre_data", 16'(tx_data), 16'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_tx_valid", 16'(tx_valid), 16'd0);
    chk("rst2_tx_data", 16'(tx_data), 16'd0);
    chk("rst2_mul_a", 16'(mul_a), 16'd0);
    chk("rst2_mul_b", 16'(mul_b), 16'd0);
    chk("rst2_busy", 16'(busy), 16'd0);
    #2 rst_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    chk("rst2_idle_valid", 16'(tx_valid), 16'd0);
    do_frame(8'h10, 8'h10, 8'h01, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
